// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for one shared 8-digit seven-segment display.
// The owner keeps the display for at least DWELL cycles and can hold it with lock.
module seg_display_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 50000000,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [8*NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]      grant,
  output logic [31:0]          output_data,
  output logic [7:0]           output_valid,
  output logic                 busy
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [PTR_W-1:0] IDX_MAX = PTR_W'(NREQ - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  valid;
  } slice_t;

  slice_t [NREQ-1:0] slices;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slices[g].data  = req_data[32*g +: 32];
    assign slices[g].valid = req_valid[8*g +: 8];
  end

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] own_q, own_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  slice_t           out_q, out_d;

  logic [PTR_W-1:0] own_inc;
  logic [PTR_W-1:0] srch_start;
  logic [NREQ-1:0]  own_oh;
  logic [NREQ-1:0]  cand;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] pos;

  assign own_inc = (own_q == IDX_MAX) ? '0 : own_q + PTR_W'(1);
  assign own_oh  = NREQ'(1) << own_q;

  // One shared search: from ptr when idle, from owner+1 (owner excluded) when showing.
  assign srch_start = (state_q == ST_SHOW) ? own_inc : ptr_q;
  assign cand       = (state_q == ST_SHOW) ? (req & ~own_oh) : req;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    pos     = '0;
    // Walk offsets high to low so the nearest candidate wins.
    for (int o = NREQ - 1; o >= 0; o--) begin
      pos = PTR_W'((int'(srch_start) + o) % NREQ);
      if (cand[pos]) begin
        hit     = 1'b1;
        hit_idx = pos;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_SHOW;
          own_d   = hit_idx;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!req[own_q]) begin
          ptr_d = own_inc;
          cnt_d = '0;
          if (hit) begin
            own_d = hit_idx;
          end else begin
            state_d = ST_IDLE;
            own_d   = '0;
          end
        end else if (cnt_q == CNT_MAX && !lock[own_q] && hit) begin
          own_d = hit_idx;
          cnt_d = '0;
          ptr_d = (hit_idx == IDX_MAX) ? '0 : hit_idx + PTR_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    grant_d = (state_d == ST_SHOW) ? (NREQ'(1) << own_d) : '0;
    out_d   = (state_d == ST_SHOW) ? slices[own_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      out_q   <= out_d;
    end
  end

  assign grant        = grant_q;
  assign output_data  = out_q.data;
  assign output_valid = out_q.valid;
  assign busy         = |grant_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against an ownership-level model.
module tb_seg_display_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [32*N-1:0] req_data = '0;
  logic [8*N-1:0] req_valid = '0;
  logic [N-1:0]   grant;
  logic [31:0]    output_data;
  logic [7:0]     output_valid;
  logic           busy;

  seg_display_arbiter #(.NREQ(N), .DWELL(DW), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .lock         (lock),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .grant        (grant),
    .output_data  (output_data),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // Model: owner index (-1 = nobody), cycles held since grant, rotation pointer.
  int m_own = -1;
  int m_held = 0;
  int m_ptr = 0;
  logic [N-1:0] e_grant = '0;
  logic [31:0]  e_data = '0;
  logic [7:0]   e_valid = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
    for (int o = 0; o < N; o++) begin
      int i;
      i = (start + o) % N;
      if (i != skip && r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Advance one clock: decide the new owner from the inputs the DUT is about to sample.
  task automatic tick();
    int own, held, ptr, nxt;
    logic [31:0] d;
    logic [7:0]  v;
    own = m_own; held = m_held; ptr = m_ptr;
    if (!rst_n) begin
      own = -1; held = 0; ptr = 0;
    end else if (own < 0) begin
      own = pick(req, ptr, -1);
      held = 0;
    end else begin
      nxt = pick(req, (own + 1) % N, own);
      if (!req[own[1:0]]) begin
        ptr = (own + 1) % N;
        own = nxt;
        held = 0;
      end else if (held >= DW - 1 && !lock[own[1:0]] && nxt >= 0) begin
        own = nxt;
        ptr = (nxt + 1) % N;
        held = 0;
      end else begin
        held++;
      end
    end
    d = (own < 0) ? 32'h0 : 32'(req_data >> (32 * own));
    v = (own < 0) ? 8'h0 : 8'(req_valid >> (8 * own));
    @(posedge clk);
    m_own = own; m_held = held; m_ptr = ptr;
    e_grant = (own < 0) ? '0 : (N'(1) << own);
    e_data  = d;
    e_valid = v;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_grant", 32'(grant), 32'(e_grant));
      chk("cyc_data", output_data, e_data);
      chk("cyc_valid", 32'(output_valid), 32'(e_valid));
      chk("cyc_busy", 32'(busy), 32'(|e_grant));
    end
  end

  task automatic do_reset();
    req = '0; lock = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_rr [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001};

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_data", output_data, 32'h0);
    chk("rst_valid", 32'(output_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single requester, data pass-through with one cycle of latency.
    req_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678};
    req_valid = {8'h80, 8'h00, 8'h3C, 8'hFF};
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_data", output_data, 32'h12345678);
    chk("t1_valid", 32'(output_valid), 32'hFF);
    chk("t1_busy", 32'(busy), 32'h1);
    req_data[31:0] = 32'hCAFEBABE;
    chk("t1_data_hold", output_data, 32'h12345678);
    tick();
    chk("t1_data_follow", output_data, 32'hCAFEBABE);

    // Two requesters rotate every DW cycles.
    req_data[31:0] = 32'h11111111;
    do_reset();
    req = 4'b0101;
    for (int t = 0; t < 12; t++) begin
      tick();
      chk("t2_grant", 32'(grant), 32'(exp_rr[t]));
      if (t == 4) begin
        chk("t2_data_sw", output_data, 32'h33333333);
        chk("t2_valid_zero", 32'(output_valid), 32'h00);
      end
    end

    // Lock holds ownership past expiry; dropping it rotates next edge.
    do_reset();
    req = 4'b0100;
    tick();
    lock = 4'b0100;
    req  = 4'b1100;
    repeat (12) tick();
    chk("t3_locked", 32'(grant), 32'h4);
    lock = '0;
    tick();
    chk("t3_unlock", 32'(grant), 32'h8);
    chk("t3_data", output_data, 32'h44444444);

    // Release mid-dwell hands over; new owner's dwell restarts; last release idles.
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    tick();
    req = 4'b1000;
    tick();
    chk("t4_release", 32'(grant), 32'h8);
    req = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("t4_dwell", 32'(grant), 32'h8);
    end
    tick();
    chk("t4_expire", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    chk("t4_idle_grant", 32'(grant), 32'h0);
    chk("t4_idle_data", output_data, 32'h0);
    chk("t4_idle_valid", 32'(output_valid), 32'h0);
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // Saturated owner yields immediately to a newcomer.
    do_reset();
    req = 4'b0001;
    repeat (11) tick();
    req = 4'b0011;
    tick();
    chk("t5_grant", 32'(grant), 32'h2);
    chk("t5_data", output_data, 32'h22222222);

    // Reset mid-ownership clears everything and restarts the pointer at 0.
    do_reset();
    req = 4'b1111;
    tick();
    repeat (4) tick();
    chk("t6_pre", 32'(grant), 32'h2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_data", output_data, 32'h0);
    chk("t6_rst_valid", 32'(output_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t6_after", 32'(grant), 32'h1);

    // Random traffic: sparse req/lock toggles, changing data, rare resets.
    for (int c = 0; c < 3000; c++) begin
      req  = req ^ (N'($urandom) & N'($urandom) & N'($urandom));
      lock = lock ^ (N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 1) == 0)
        req_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        req_valid = 32'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
